// File: rtl/regfile_write_arbiter_if.sv
// Write-request bus between the producers (ALU, load unit, I/O unit),
// the decode reservation port and the register-bank write scheduler.
interface regfile_write_arbiter_if #(
  parameter int NREQ = 3,
  parameter int NREG = 8,
  parameter int W    = 16,
  parameter int AW   = (NREG > 1) ? $clog2(NREG) : 1
) ();

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*W-1:0]  req_data;
  logic [NREQ-1:0]    req_ready;
  logic               rsv_valid;
  logic [AW-1:0]      rsv_addr;
  logic               flush;
  logic [NREG-1:0]    reg_en;
  logic [W-1:0]       reg_wdata;
  logic [NREG-1:0]    busy;

  // Requester / decode side
  modport master (
    output req_valid, req_addr, req_data, rsv_valid, rsv_addr, flush,
    input  req_ready, reg_en, reg_wdata, busy
  );

  // Scheduler side
  modport slave (
    input  req_valid, req_addr, req_data, rsv_valid, rsv_addr, flush,
    output req_ready, reg_en, reg_wdata, busy
  );

endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin write-port scheduler for the register bank. One request is
// granted per cycle, registered into a single write stage that drives a
// one-hot register enable the next cycle, and a per-register busy
// scoreboard tracks reservations from decode until their write lands.
module regfile_write_arbiter #(
  parameter int NREQ = 3,
  parameter int NREG = 8,
  parameter int W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_b,   // active-high asynchronous reset
  regfile_write_arbiter_if.slave   bus
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int PW = $clog2(NREQ);

  // First valid requester at or after position p, wrapping modulo NREQ.
  function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] v,
                                               input logic [PW-1:0]   p);
    logic [NREQ-1:0] g;
    logic            found;
    logic [PW:0]     pos;
    g     = {NREQ{1'b0}};
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, p} + (PW+1)'(k);
      if (pos >= (PW+1)'(NREQ)) pos = pos - (PW+1)'(NREQ);
      else                      pos = pos;
      if (!found && v[pos[PW-1:0]]) begin
        g[pos[PW-1:0]] = 1'b1;
        found          = 1'b1;
      end else begin
        found = found;
      end
    end
    return g;
  endfunction

  // One-hot register select; addresses beyond NREG-1 select nothing.
  function automatic logic [NREG-1:0] addr_dec(input logic [AW-1:0] a);
    logic [NREG-1:0] o;
    for (int k = 0; k < NREG; k++) o[k] = (a == AW'(k));
    return o;
  endfunction

  logic [PW-1:0]   ptr_r;
  logic            wr_v_r;
  logic [AW-1:0]   wr_addr_r;
  logic [W-1:0]    wr_data_r;
  logic [NREG-1:0] busy_r;

  logic [NREQ-1:0] grant_s;
  logic            accept_s;
  logic [PW-1:0]   ptr_nxt_s;
  logic [AW-1:0]   sel_addr_s;
  logic [W-1:0]    sel_data_s;
  logic [NREG-1:0] reg_en_s;
  logic [NREG-1:0] rsv_set_s;

  // Grant: no grant while in reset or flushing, else round-robin pick.
  always_comb begin
    grant_s = {NREQ{1'b0}};
    if (rst_b || bus.flush) grant_s = {NREQ{1'b0}};
    else                    grant_s = rr_pick(bus.req_valid, ptr_r);
  end

  // Mux the granted requester's address/data and the next pointer value.
  always_comb begin
    accept_s   = 1'b0;
    ptr_nxt_s  = ptr_r;
    sel_addr_s = {AW{1'b0}};
    sel_data_s = {W{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      if (grant_s[k]) begin
        accept_s   = 1'b1;
        ptr_nxt_s  = PW'((k + 1) % NREQ);
        sel_addr_s = bus.req_addr[k*AW +: AW];
        sel_data_s = bus.req_data[k*W +: W];
      end else begin
        accept_s = accept_s;
      end
    end
  end

  // Enable and reservation decode from the write stage and decode port.
  always_comb begin
    reg_en_s  = {NREG{1'b0}};
    rsv_set_s = {NREG{1'b0}};
    if (wr_v_r) reg_en_s = addr_dec(wr_addr_r);
    else        reg_en_s = {NREG{1'b0}};
    if (bus.rsv_valid) rsv_set_s = addr_dec(bus.rsv_addr);
    else               rsv_set_s = {NREG{1'b0}};
  end

  assign bus.req_ready = grant_s;
  assign bus.reg_en    = reg_en_s;
  assign bus.reg_wdata = wr_data_r;
  assign bus.busy      = busy_r;

  // Round-robin pointer and write stage; flush kills the next write only.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      ptr_r     <= {PW{1'b0}};
      wr_v_r    <= 1'b0;
      wr_addr_r <= {AW{1'b0}};
      wr_data_r <= {W{1'b0}};
    end else if (bus.flush) begin
      wr_v_r <= 1'b0;
    end else if (accept_s) begin
      ptr_r     <= ptr_nxt_s;
      wr_v_r    <= 1'b1;
      wr_addr_r <= sel_addr_s;
      wr_data_r <= sel_data_s;
    end else begin
      wr_v_r <= 1'b0;
    end
  end

  // Busy scoreboard: a new reservation wins over a same-cycle completion.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      busy_r <= {NREG{1'b0}};
    end else if (bus.flush) begin
      busy_r <= {NREG{1'b0}};
    end else begin
      busy_r <= (busy_r & ~reg_en_s) | rsv_set_s;
    end
  end

endmodule
